// File: rtl/shift_pkg.sv
// shift_pkg: op codes, FSM states and op classification shared by the shifter and control unit
package shift_pkg;
  localparam logic [2:0] SH_PASS = 3'b000;
  localparam logic [2:0] SH_SLL  = 3'b001;
  localparam logic [2:0] SH_SRL  = 3'b010;
  localparam logic [2:0] SH_SRA  = 3'b011;
  localparam logic [2:0] SH_ROR  = 3'b100;
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;
  function automatic logic is_shift(input logic [2:0] o);
    return o inside {SH_SLL, SH_SRL, SH_SRA, SH_ROR};
  endfunction
endpackage

// File: rtl/shift_step.sv
// shift_step: one-bit shift/rotate of a value; pass and reserved codes leave it unchanged
module shift_step import shift_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_comb
    q = op == SH_SLL ? {d[WIDTH-2:0], 1'b0} :
        op == SH_SRL ? {1'b0, d[WIDTH-1:1]} :
        op == SH_SRA ? {d[WIDTH-1], d[WIDTH-1:1]} :
        op == SH_ROR ? {d[0], d[WIDTH-1:1]} : d;
endmodule

// File: rtl/shift_unit_seq.sv
// shift_unit_seq: iterative shifter, one bit per clock, one-cycle done pulse on completion
module shift_unit_seq import shift_pkg::*; #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   result,
  output logic               busy,
  output logic               done
);
  state_t state, state_n;
  logic [WIDTH-1:0] result_n, step;
  logic [2:0] op_q, op_n;
  logic [SHAMT_W-1:0] count, count_n;
  shift_step #(.WIDTH(WIDTH)) u_step (.op(op_q), .d(result), .q(step));
  always_ff @(posedge clk)
    if (reset) begin
      state  <= ST_IDLE;
      result <= '0;
      op_q   <= SH_PASS;
      count  <= '0;
    end else begin
      state  <= state_n;
      result <= result_n;
      op_q   <= op_n;
      count  <= count_n;
    end
  // zero-length or non-shift ops skip SHIFT so the control FSM always sees a done pulse
  always_comb begin
    state_n  = state;
    result_n = result;
    op_n     = op_q;
    count_n  = count;
    if (state == ST_IDLE && start) begin
      result_n = data_in;
      op_n     = op;
      count_n  = shamt;
      state_n  = (shamt == '0 || !is_shift(op)) ? ST_DONE : ST_SHIFT;
    end else if (state == ST_SHIFT) begin
      result_n = step;
      count_n  = count - 1'b1;
      state_n  = count == SHAMT_W'(1) ? ST_DONE : ST_SHIFT;
    end else if (state == ST_DONE)
      state_n = ST_IDLE;
  end
  assign busy = state == ST_SHIFT;
  assign done = state == ST_DONE;
endmodule
